// File: rtl/spi_cfg_ctrl.sv
// SPI mode-0 slave that receives 16-bit write frames and updates five 8-bit
// PWM configuration registers. All SPI pins are synchronized into clk.
module spi_cfg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_copi,
    input  logic       spi_ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       cfg_wr_pulse,
    output logic       frame_err
);

    localparam int CNT_W    = $clog2(FRAME_BITS + 2);
    localparam int NUM_REGS = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
    logic                   sclk_d, ncs_d;
    logic                   sclk_s, ncs_s, copi_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    logic [FRAME_BITS-1:0]  shift_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             regs_q [NUM_REGS];

    logic                   frame_start, shift_en, wr_en, err_en;
    logic                   frame_cmd;
    logic [6:0]             frame_addr;
    logic [7:0]             frame_data;

    // Idle levels on reset keep a reset release from looking like an SPI edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            copi_sync <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi_ncs};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    assign frame_cmd  = shift_q[FRAME_BITS-1];
    assign frame_addr = shift_q[14:8];
    assign frame_data = shift_q[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        wr_en       = 1'b0;
        err_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    state_d     = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        wr_en = frame_cmd && (frame_addr <= 7'(NUM_REGS - 1));
                    end else begin
                        err_en = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (frame_start) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
            if (cnt_q < CNT_W'(FRAME_BITS + 1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the register array is small and drives outputs, so every entry is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cfg_wr_pulse <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cfg_wr_pulse <= wr_en;
            frame_err    <= err_en;
            if (wr_en) begin
                regs_q[frame_addr[2:0]] <= frame_data;
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];

endmodule
